// File: rtl/toggle_event_receiver_pkg.sv
// rtl/toggle_event_receiver_pkg.sv - shared types and helpers for toggle_event_receiver
package toggle_event_receiver_pkg;

    typedef struct packed {
        logic sync_prev;
        logic overflow;
    } chan_state_t;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/ff_synchronizer.sv
// rtl/ff_synchronizer.sv - multi-bit flop-chain synchronizer, async active-high reset
module ff_synchronizer #(
    parameter int unsigned          WIDTH        = 1,
    parameter int unsigned          EXTRA_STAGES = 0,
    parameter logic [WIDTH-1:0]     RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned STAGES = 2 + EXTRA_STAGES;

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) chain[s] <= RESET_VALUE;
        end else begin
            chain[0] <= d;
            for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// rtl/toggle_event_receiver.sv - toggle events to per-channel pending counters with valid/ready
// Optional overflow flags: TOGGLE_EVENT_RECEIVER_OVERFLOW_EN
module toggle_event_receiver
    import toggle_event_receiver_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned EXTRA_STAGES = 0,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           async_toggle,
    output logic [CHANNELS-1:0]           event_valid,
    input  logic [CHANNELS-1:0]           event_ready,
    output logic [CHANNELS*CNT_WIDTH-1:0] event_count,
    output logic [CHANNELS-1:0]           overflow,
    input  logic [CHANNELS-1:0]           overflow_clear
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic [CHANNELS-1:0] sync;

    ff_synchronizer #(
        .WIDTH        (CHANNELS),
        .EXTRA_STAGES (EXTRA_STAGES),
        .RESET_VALUE  ({CHANNELS{1'b0}})
    ) u_sync (
        .clk   (clk),
        .reset (!reset_n),
        .d     (async_toggle),
        .q     (sync)
    );

`ifndef TOGGLE_EVENT_RECEIVER_OVERFLOW_EN
    logic unused_overflow_clear;
    assign unused_overflow_clear = ^overflow_clear;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        chan_state_t          st;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 inc;
        logic                 dec;
        logic                 ovf_next;

        always_comb begin
            inc      = sync[i] ^ st.sync_prev;
            dec      = (cnt != '0) & event_ready[i];
            ovf_next = 1'b0;
`ifdef TOGGLE_EVENT_RECEIVER_OVERFLOW_EN
            // A drop on the same cycle as a clear keeps the flag set.
            ovf_next = (inc & !dec & (cnt == CNT_MAX)) | (st.overflow & !overflow_clear[i]);
`endif
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt          <= '0;
                st.sync_prev <= 1'b0;
                st.overflow  <= 1'b0;
            end else begin
                st.sync_prev <= sync[i];
                st.overflow  <= ovf_next;
                if (inc && !dec && cnt != CNT_MAX) cnt <= cnt + 1'b1;
                else if (dec && !inc)              cnt <= cnt - 1'b1;
            end
        end

        assign event_valid[i]                       = (cnt != '0);
        assign event_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
        assign overflow[i]                          = st.overflow;
    end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// tb/tb_toggle_event_receiver.sv - directed self-checking bench for toggle_event_receiver
module tb_toggle_event_receiver;

    localparam int CH = 4;
    localparam int CW = 4;

    logic             clk;
    logic             reset_n;
    logic [CH-1:0]    async_toggle;
    logic [CH-1:0]    event_valid;
    logic [CH-1:0]    event_ready;
    logic [CH*CW-1:0] event_count;
    logic [CH-1:0]    overflow;
    logic [CH-1:0]    overflow_clear;

    int total = 0;
    int bad   = 0;

`ifdef TOGGLE_EVENT_RECEIVER_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    toggle_event_receiver #(.CHANNELS(CH), .EXTRA_STAGES(0), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .async_toggle   (async_toggle),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_count    (event_count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return event_count[ch*CW +: CW];
    endfunction

    task automatic toggle_n(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            async_toggle[ch] = ~async_toggle[ch];
            tick(2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [CH-1:0] mask;
        reset_n        = 1'b0;
        async_toggle   = '0;
        event_ready    = '0;
        overflow_clear = '0;
        tick(3);
        check("rst_valid", 32'(event_valid), 32'h0);
        check("rst_count", 32'(event_count), 32'h0);
        check("rst_ovf",   32'(overflow),    32'h0);
        reset_n = 1'b1;
        tick(2);

        // single event: flip after edge 0, valid appears after edge 3
        async_toggle[0] = 1'b1;
        tick(2);
        check("single_lat_e2", 32'(event_valid[0]), 32'h0);
        tick();
        check("single_valid", 32'(event_valid[0]), 32'h1);
        check("single_count", 32'(cnt_of(0)), 32'h1);
        event_ready[0] = 1'b1;
        tick();
        event_ready[0] = 1'b0;
        check("single_drain_cnt", 32'(cnt_of(0)), 32'h0);
        check("single_drain_vld", 32'(event_valid[0]), 32'h0);

        // burst of 5 on channel 2
        toggle_n(2, 5);
        tick(2);
        check("burst_count", 32'(cnt_of(2)), 32'd5);
        event_ready[2] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (event_valid[2]) n++;
            tick();
        end
        event_ready[2] = 1'b0;
        check("burst_valid_cycles", 32'(n), 32'd5);
        check("burst_no_underflow", 32'(cnt_of(2)), 32'd0);

        // simultaneous inc/dec at 3 and at max on channel 1
        toggle_n(1, 3);
        tick(2);
        check("sim3_pre", 32'(cnt_of(1)), 32'd3);
        async_toggle[1] = ~async_toggle[1];
        tick(2);
        event_ready[1] = 1'b1;
        tick();
        event_ready[1] = 1'b0;
        check("sim3_hold", 32'(cnt_of(1)), 32'd3);
        tick();
        check("sim3_after", 32'(cnt_of(1)), 32'd3);
        toggle_n(1, 12);
        tick(2);
        check("sim15_pre", 32'(cnt_of(1)), 32'd15);
        async_toggle[1] = ~async_toggle[1];
        tick(2);
        event_ready[1] = 1'b1;
        tick();
        event_ready[1] = 1'b0;
        check("sim15_hold", 32'(cnt_of(1)), 32'd15);
        tick();
        check("sim15_ovf", 32'(overflow[1]), 32'h0);

        // saturation on channel 3
        toggle_n(3, 17);
        tick(2);
        check("sat_count", 32'(cnt_of(3)), 32'd15);
        check("sat_ovf", 32'(overflow[3]), 32'(OVF_EXP));
        check("sat_ovf_others", 32'(overflow[2:0]), 32'h0);
        overflow_clear[3] = 1'b1;
        tick();
        overflow_clear[3] = 1'b0;
        check("sat_ovf_clr", 32'(overflow[3]), 32'h0);

        event_ready = '1;
        tick(20);
        event_ready = '0;
        check("drain_all", 32'(event_count), 32'h0);

        // independence: channel i gets i+1 simultaneous events
        for (int k = 0; k < CH; k++) begin
            mask = '0;
            for (int i = k; i < CH; i++) mask[i] = 1'b1;
            async_toggle = async_toggle ^ mask;
            tick(2);
        end
        tick(2);
        for (int i = 0; i < CH; i++)
            check($sformatf("indep_ch%0d", i), 32'(cnt_of(i)), 32'(i + 1));
        check("indep_valid", 32'(event_valid), 32'hF);

        // reset mid-operation with events in flight
        async_toggle = '0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(event_valid), 32'h0);
        check("mid_rst_count", 32'(event_count), 32'h0);
        check("mid_rst_ovf",   32'(overflow),    32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("post_rst_count", 32'(event_count), 32'h0);
        check("post_rst_valid", 32'(event_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
